// File: rtl/pulse_merge_scheduler.sv
// Merges single-cycle events from N_REQ requesters onto one pulse line.
// Each requester owns a one-deep pending flag; a round-robin arbiter grants one
// requester at a time, a one-cycle FIRE is followed by GAP HOLD cycles, and events
// that hit an already-pending requester are counted in a saturating drop counter.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req_pulse per-requester event strobes
//   q         merged output pulse (registered, one cycle per grant)
//   q_src     index of the requester served while q=1, otherwise 0
//   pend      per-requester pending flags
//   busy      high while the scheduler is not idle
//   drop_cnt  saturating count of lost events
module pulse_merge_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned GAP   = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_pulse,
  output logic                       q,
  output logic [$clog2(N_REQ)-1:0]   q_src,
  output logic [N_REQ-1:0]           pend,
  output logic                       busy,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned SumW = CNT_W + 5;
  // HOLD is entered with GAP-1 and left when the counter reaches zero.
  localparam logic [3:0] HoldInit = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StFire, StHold} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   win_q, win_d;
  logic [3:0]        hold_q, hold_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              q_q;
  logic [IdxW-1:0]   q_src_q;

  logic [IdxW-1:0]   rr_win;
  logic              rr_found;
  logic [N_REQ-1:0]  grant_vec;
  logic [N_REQ-1:0]  drops;
  logic [SumW-1:0]   drop_sum;
  int unsigned       cand;

  // Round-robin search starting at ptr_q, wrapping at N_REQ-1.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = ptr_q;
    cand     = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = (32'(ptr_q) + off) % N_REQ;
      if (!rr_found && pend_q[IdxW'(cand)]) begin
        rr_found = 1'b1;
        rr_win   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    hold_d    = hold_q;
    grant_vec = '0;
    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          state_d           = StFire;
          win_d             = rr_win;
          grant_vec[rr_win] = 1'b1;
          ptr_d             = (rr_win == IdxW'(N_REQ - 1)) ? '0 : rr_win + 1'b1;
        end
      end
      StFire: begin
        if (GAP > 0) begin
          state_d = StHold;
          hold_d  = HoldInit;
        end else begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (hold_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new event always sets its flag, even on the edge that grants it.
  always_comb begin
    pend_d   = req_pulse | (pend_q & ~grant_vec);
    drops    = req_pulse & pend_q & ~grant_vec;
    drop_sum = SumW'(drop_q);
    for (int unsigned i = 0; i < N_REQ; i++) begin
      drop_sum = drop_sum + SumW'(drops[i]);
    end
    drop_d = (|drop_sum[SumW-1:CNT_W]) ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      hold_q  <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
      q_q     <= 1'b0;
      q_src_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      q_q     <= (state_q == StFire);
      q_src_q <= (state_q == StFire) ? win_q : '0;
    end
  end

  assign q        = q_q;
  assign q_src    = q_src_q;
  assign pend     = pend_q;
  assign busy     = (state_q != StIdle);
  assign drop_cnt = drop_q;

endmodule

// File: doc/pulse_merge_scheduler.md
PULSE_MERGE_SCHEDULER -- requirements
Module: pulse_merge_scheduler

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset, as decided: one clock; reset is asynchronous and active-high.
REQ-002 Parameter N_REQ, default 4: number of requesters; legal range 2..16.
REQ-003 Parameter GAP, default 3: idle cycles enforced after each output pulse; legal range 0..15.
REQ-004 Parameter CNT_W, default 8: width of the drop counter.
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port req_pulse, input, N_REQ bits: bit i high for one cycle means one SFQ event from requester i.
REQ-008 Port q, output, 1 bit: merged pulse line, registered, high for exactly one cycle per granted event.
REQ-009 Port q_src, output, clog2(N_REQ) bits: index of the requester being served; valid only while q=1, 0 otherwise.
REQ-010 Port pend, output, N_REQ bits: registered per-requester pending flags.
REQ-011 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 Port drop_cnt, output, CNT_W bits: saturating count of lost events.

Function
REQ-013 Each requester SHALL have a one-deep pending flag that is set at any clock edge where req_pulse[i]=1.
REQ-014 The FSM SHALL have exactly three states: IDLE, FIRE and HOLD.
REQ-015 IDLE: at an edge with pend nonzero, the FSM SHALL grant one requester, go to FIRE, and clear that requester's pend bit; otherwise it stays in IDLE.
REQ-016 Arbitration SHALL be round-robin:
- The search starts at pointer ptr and wraps from N_REQ-1 to 0.
- The first set pend bit wins.
- At the grant edge, ptr becomes (winner+1) mod N_REQ.
REQ-017 FIRE SHALL last exactly one cycle with q=1 and q_src=winner. From FIRE, the FSM goes to HOLD if GAP>0, or to IDLE if GAP=0.
REQ-018 HOLD SHALL last exactly GAP cycles, timed by an internal down-counter, then go to IDLE. No grant is made in FIRE or HOLD.
REQ-019 Output pulse spacing: consecutive q pulses SHALL be at least GAP+2 cycles apart, rising edge to rising edge.
REQ-020 Latency: with the FSM in IDLE and no contention, q SHALL be high during the cycle beginning 2 rising edges after the edge that sampled req_pulse.
REQ-021 Grant and new request on the same requester at the same edge: the set SHALL win, so pend[i] stays 1 and the new event is not dropped.
REQ-022 An event SHALL count as a drop when req_pulse[i]=1 and pend[i]=1 at an edge that does not grant requester i; the event is lost and pend[i] stays 1.
REQ-023 Drop counting:
- drop_cnt SHALL increase by the number of drops at that edge (several at once are possible).
- drop_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 A requester whose pend bit is set SHALL be served within N_REQ grants.

Reset
REQ-025 While rst=1, independent of clk, the block SHALL force: state IDLE, q=0, q_src=0, pend=0, busy=0, drop_cnt=0, ptr=0, hold counter=0.
REQ-026 Reset asserted mid-FIRE or mid-HOLD SHALL abort immediately, discarding all pending events, with no q pulse emitted after rst rises.
REQ-027 After rst falls, the first grant SHALL be possible at the first clk edge that sees pend nonzero.

Verification (N_REQ=4, GAP=3, CNT_W=8)
REQ-028 Single event: req_pulse=0001 at edge k -> pend=0001 after k; q=1 and q_src=0 in the cycle after edge k+2; busy=1 for 4 cycles (FIRE plus 3 HOLD).
REQ-029 Contention: req_pulse=1111 at one edge -> q pulses with q_src 0,1,2,3 in that order, each 5 cycles apart; drop_cnt=0.
REQ-030 Fairness: requester 0 pulsing every cycle while requester 2 pulses once -> requester 2 is served no later than the second grant after its pend bit sets; requester 0 drops are counted.
REQ-031 Set-wins: req_pulse[1]=1 on the exact grant edge of requester 1 -> pend[1] stays 1, drop_cnt unchanged, and a second q pulse with q_src=1 follows.
REQ-032 Saturation: 300 drops on requester 3 -> drop_cnt=255 and holds there.
REQ-033 Asynchronous reset: rst pulsed between clock edges during HOLD with pend=0110 -> all outputs 0 immediately, no q pulse follows; a new req_pulse=0100 -> q_src=2 (ptr back at 0).
